// File: rtl/ex_div_sequencer.sv
// ex_div_sequencer: multi-cycle RV32M divide/remainder controller using radix-2 restoring division
module ex_div_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        flush,
    input  logic [1:0]  op,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        busy,
    output logic        freeze_pipe,
    output logic        done,
    output logic [31:0] result
);
    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
    state_t      state;
    logic [1:0]  op_q;
    logic [31:0] quo, dmag;
    logic [32:0] rem;
    logic [4:0]  cnt;
    logic        sign_q, sign_r;
    logic        is_signed, accept, div_zero, ovf;
    logic [31:0] a_mag, b_mag, q_fix, r_fix;
    logic [32:0] shifted, trial;
    always_comb begin
        is_signed = !op[0];
        accept    = state == IDLE && start && !flush;
        div_zero  = divisor == 32'd0;
        ovf       = is_signed && dividend == 32'h8000_0000 && divisor == 32'hFFFF_FFFF;
        a_mag     = is_signed && dividend[31] ? -dividend : dividend;
        b_mag     = is_signed && divisor[31] ? -divisor : divisor;
        shifted   = {rem[31:0], quo[31]};
        trial     = shifted - {1'b0, dmag};
        q_fix     = sign_q ? -quo : quo;
        r_fix     = sign_r ? -rem[31:0] : rem[31:0];
    end
    assign busy        = state != IDLE;
    assign done        = state == DONE;
    // request-cycle term stalls the pipe before the operands are even latched
    assign freeze_pipe = accept || state == CALC || state == FIX;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            op_q   <= '0;
            quo    <= '0;
            dmag   <= '0;
            rem    <= '0;
            cnt    <= '0;
            sign_q <= 1'b0;
            sign_r <= 1'b0;
            result <= '0;
        end else if (flush) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: if (start) begin
                    op_q   <= op;
                    quo    <= a_mag;
                    dmag   <= b_mag;
                    sign_q <= is_signed && (dividend[31] ^ divisor[31]);
                    sign_r <= is_signed && dividend[31];
                    rem    <= '0;
                    cnt    <= '0;
                    if (div_zero || ovf) begin
                        result <= div_zero ? (op[1] ? dividend : 32'hFFFF_FFFF)
                                           : (op[1] ? 32'd0 : 32'h8000_0000);
                        state  <= DONE;
                    end else begin
                        state <= CALC;
                    end
                end
                CALC: begin
                    rem   <= trial[32] ? shifted : trial;
                    quo   <= {quo[30:0], !trial[32]};
                    cnt   <= cnt + 5'd1;
                    state <= cnt == 5'd31 ? FIX : CALC;
                end
                FIX: begin
                    result <= op_q[1] ? r_fix : q_fix;
                    state  <= DONE;
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ex_div_sequencer.sv
// tb_ex_div_sequencer: directed checks of latency, results, special cases, flush and reset
module tb_ex_div_sequencer;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic        busy, freeze_pipe, done;
    logic [31:0] result;
    int total = 0;
    int bad = 0;

    ex_div_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .flush(flush), .op(op),
        .dividend(dividend), .divisor(divisor), .busy(busy),
        .freeze_pipe(freeze_pipe), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // issue one request and wait for done; pulse_at>0 re-pulses start mid-run with junk operands
    task automatic run(input string tag, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_r, input int exp_lat, input int pulse_at);
        int lat;
        logic frz_gap;
        @(negedge clk);
        op = o; dividend = a; divisor = b; start = 1'b1;
        #1;
        chk({tag, "_frz_req"}, {31'd0, freeze_pipe}, 32'd1);
        chk({tag, "_idle_req"}, {30'd0, busy, done}, 32'd0);
        @(posedge clk);
        #1 start = 1'b0;
        lat = 0;
        frz_gap = 1'b0;
        while (lat < 50) begin
            @(negedge clk);
            lat++;
            if (done) break;
            if (!freeze_pipe || !busy) frz_gap = 1'b1;
            if (lat == pulse_at) begin
                op = 2'b01; dividend = 32'd50; divisor = 32'd5; start = 1'b1;
                @(posedge clk);
                #1 start = 1'b0;
            end
        end
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_res"}, result, exp_r);
        chk({tag, "_frz_run"}, {31'd0, frz_gap}, 32'd0);
        chk({tag, "_frz_done"}, {30'd0, freeze_pipe, busy}, 32'd1);
    endtask

    initial begin
        bit seen;
        #1;
        chk("reset_out", {busy, freeze_pipe, done}, 32'd0);
        chk("reset_res", result, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        run("divu_100_7", 2'b01, 32'd100, 32'd7, 32'd14, 34, 0);
        run("remu_100_7", 2'b11, 32'd100, 32'd7, 32'd2, 34, 0);
        run("div_m7_2", 2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34, 0);
        run("rem_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34, 0);
        run("div_by0", 2'b00, 32'h1234, 32'd0, 32'hFFFF_FFFF, 1, 0);
        run("rem_by0", 2'b10, 32'h1234, 32'd0, 32'h1234, 1, 0);
        run("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0);
        run("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, 0);
        run("divu_big", 2'b01, 32'hFFFF_FFFF, 32'd16, 32'h0FFF_FFFF, 34, 0);
        run("div_neg_div", 2'b00, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 34, 0);
        run("rem_neg_div", 2'b10, 32'd100, 32'hFFFF_FFF9, 32'd2, 34, 0);
        run("start_ignored", 2'b01, 32'd100, 32'd7, 32'd14, 34, 5);

        // flush at cycle 10 of a long divide: no done, result untouched
        @(negedge clk);
        op = 2'b01; dividend = 32'hFFFF_FFFF; divisor = 32'd3; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        chk("flush_idle", {busy, freeze_pipe, done}, 32'd0);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        chk("flush_no_done", {31'd0, seen}, 32'd0);
        chk("flush_res", result, 32'd14);
        run("divu_9_3", 2'b01, 32'd9, 32'd3, 32'd3, 34, 0);

        // async reset mid-CALC
        @(negedge clk);
        op = 2'b01; dividend = 32'd1000; divisor = 32'd10; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (8) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_mid_out", {busy, freeze_pipe, done}, 32'd0);
        chk("rst_mid_res", result, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) seen = 1'b1;
        end
        chk("rst_no_done", {31'd0, seen}, 32'd0);
        run("after_rst", 2'b01, 32'd1000, 32'd10, 32'd100, 34, 0);
        run("b2b_remu", 2'b11, 32'd1000, 32'd7, 32'd6, 34, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ex_div_sequencer.md
# ex_div_sequencer

Multi-cycle divide controller for the execution stage. It accepts a divide/remainder request (RV32M DIV, DIVU, REM, REMU) alongside the ALU operands and runs a radix-2 restoring division over 32 iterations. While it runs, it holds the pipeline with `freeze_pipe`, then presents the 32-bit result with a one-cycle `done` pulse. It is the sequencer behind the ALU's `div_en`/`freeze_pipe` pair.

## Interface
- No parameters; data width is fixed at 32.
- `clk` — input — 1 — clock; all state updates on the rising edge.
- `rst` — input — 1 — asynchronous, active-low reset.
- `start` — input — 1 — request; sampled only in IDLE.
- `flush` — input — 1 — synchronous abort of any in-flight operation.
- `op` — input — 2 — operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU (funct3[1:0]).
- `dividend` — input — 32 — rs1 operand; sampled with `start`.
- `divisor` — input — 32 — rs2 operand; sampled with `start`.
- `busy` — output — 1 — high whenever state is not IDLE.
- `freeze_pipe` — output — 1 — stall request to the pipeline registers.
- `done` — output — 1 — one-cycle pulse; `result` is valid while it is high.
- `result` — output — 32 — quotient or remainder.

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE, on `start` & !`flush`:
  - latch `op`, magnitudes |dividend| and |divisor|; magnitudes are taken only for signed ops, DIVU/REMU use raw values.
  - latch sign_q = dividend[31]^divisor[31] and sign_r = dividend[31] (both forced to 0 for unsigned ops).
  - clear the 33-bit partial remainder and the 5-bit iteration counter.
- Special cases are detected in IDLE and go straight to DONE (no CALC):
  - divisor == 0: quotient = 0xFFFFFFFF, remainder = dividend.
  - signed overflow (DIV/REM with dividend 0x80000000 and divisor 0xFFFFFFFF): quotient = 0x80000000, remainder = 0.
- CALC, one iteration per cycle:
  - shift {rem, quo} left by 1;
  - trial = rem − divisor_mag, 33-bit;
  - if trial is non-negative: rem = trial and quo[0] = 1, else quo[0] = 0.
  - counter increments each cycle; after the 32nd iteration (counter == 31) go to FIX.
- FIX:
  - quo negated (two's complement) if sign_q; rem negated if sign_r;
  - `result` loads quo for ops 00/01 and rem for ops 10/11; then go to DONE.
- DONE: `done` = 1 for exactly one cycle, then IDLE.
- `result` holds its value until the next completed operation.
- `start` outside IDLE is ignored; it is not queued.
- `flush` in any state returns to IDLE on the next edge:
  - no `done` pulse, `result` unchanged.
  - `flush` wins over a simultaneous `start`.

## Timing
- Reset: state IDLE; `busy`, `freeze_pipe`, `done` = 0; `result` = 0; internal registers cleared.
- Reset asserted mid-operation aborts immediately, with no `done`.
- Normal latency:
  - `start` sampled at edge E0; CALC runs during cycles after edges E0..E31; FIX after E32; `done` high in the cycle after E33.
  - That is 34 cycles from `start` to `done`.
- Special-case latency: `done` high in the cycle after E0 (1 cycle).
- `freeze_pipe` = (IDLE & `start` & !`flush`) | CALC | FIX.
  - The combinational term in IDLE stalls the pipe in the request cycle itself.
  - `freeze_pipe` is 0 in DONE so the pipeline captures `result` on the edge ending DONE.
- Back-to-back: a `start` can be accepted in the IDLE cycle immediately after DONE.
- Minimum issue interval: 35 cycles normal, 2 cycles special.

## Test plan
- DIVU 100 / 7 -> `done` exactly 34 cycles after `start`, `result` = 14; REMU on the same operands -> `result` = 2.
- DIV −7 (0xFFFFFFF9) / 2 -> `result` = 0xFFFFFFFD (−3); REM -> `result` = 0xFFFFFFFF (−1), sign of dividend.
- Divide by zero:
  - DIV 0x1234 / 0 -> `result` = 0xFFFFFFFF after 1 cycle;
  - REM 0x1234 / 0 -> `result` = 0x1234; `freeze_pipe` high only in the `start` cycle.
- Overflow: DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM -> 0; both take 1 cycle.
- `flush` at cycle 10 of a DIVU 0xFFFFFFFF / 3 -> IDLE next edge, no `done`, `result` keeps its previous value; a new DIVU 9 / 3 then yields 3.
- `start` pulsed during CALC is ignored; `rst` low mid-CALC -> all outputs 0 immediately, no `done` after release.
